instruction_prefetch: RTL

Instruction fetch front-end that sits directly upstream of the byte-addressed 32-bit bootrom/RAM: it drives the memory address with the fetch PC and captures the combinational read data. Captured words go into a small prefetch FIFO that feeds the decoder through a valid/ready handshake. It handles branch redirects by flushing the FIFO, and yields the shared memory port to load/store traffic via a grant input.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/prefetch_fifo.sv | 67 ++++++
 rtl/instruction_prefetch.sv | 68 ++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, PC step, NOP encoding
// and the {pc, word} bundle carried by the fetch queue.
package cpu_pkg;

  localparam int          WORD_W    = 32;
  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] word;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] align_word(
    input logic [WORD_W-1:0] a
  );
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO with push/pop/flush and reset-cleared storage.
// Flush wins over push and pop; pointers wrap naturally.
module prefetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Pointer and occupancy next-state
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Pointer/occupancy registers
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write; cleared on reset so the head reads zero
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/instruction_prefetch.sv
// Fetch front-end: owns the fetch PC, captures memory words into
// the prefetch FIFO, and gives branch redirects priority.
module instruction_prefetch
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        fetch_reset,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_read_data,
  input  logic        mem_grant,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         push, pop, fifo_full;
  fetch_entry_t wr_entry, head;

  // A redirect cycle neither consumes nor captures
  assign pop  = instr_valid & instr_ready & ~branch_valid;
  assign push = mem_grant & ~branch_valid & (~fifo_full | pop);

  assign wr_entry.pc   = fetch_pc_q;
  assign wr_entry.word = mem_read_data;

  prefetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (fetch_reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (branch_valid),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .valid_o (instr_valid),
    .full_o  (fifo_full)
  );

  // Fetch PC next-state: redirect, advance on capture, else hold
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (branch_valid) begin
      fetch_pc_d = align_word(branch_target);
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_INC;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk) begin
    if (fetch_reset) fetch_pc_q <= RESET_PC;
    else             fetch_pc_q <= fetch_pc_d;
  end

  assign mem_address = fetch_pc_q;
  assign instr       = head.word;
  assign instr_pc    = head.pc;

endmodule
